// File: rtl/d8_regfile_pkg.sv
// Shared types and defaults for the d8 register file.
// Holds the sweep FSM state encoding and the default geometry.
package d8_regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic {
        D8_RF_IDLE  = 1'b0,
        D8_RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/d8_regfile_clear.sv
// Clear-sweep controller: walks every entry once, writing zero, after reset or clr.
// busy comes straight from the state register, so there is no clr-to-busy path.
module d8_regfile_clear
    import d8_regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output rf_state_e         state
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= D8_RF_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                D8_RF_IDLE: begin
                    if (clr) begin
                        state <= D8_RF_CLEAR;
                        cnt   <= '0;
                    end
                end
                D8_RF_CLEAR: begin
                    // A clr during the sweep still zeroes the current entry, then restarts.
                    if (clr) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= D8_RF_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign busy     = (state == D8_RF_CLEAR);
    assign clr_we   = busy && !sys_rst;
    assign clr_addr = cnt;

endmodule

// File: rtl/d8_regfile.sv
// d8 register file: two read ports, two write ports (w1 has priority), same-cycle
// forwarding, and a sequential clear sweep so storage needs no per-entry reset.
module d8_regfile
    import d8_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr,
    output logic              busy,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    input  logic              w0,
    input  logic [ADDR_W-1:0] addr_w0,
    input  logic [DATA_W-1:0] data_w0,
    input  logic              w1,
    input  logic [ADDR_W-1:0] addr_w1,
    input  logic [DATA_W-1:0] data_w1,
    output rf_state_e         dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;

    d8_regfile_clear #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .state    (dbg_state)
    );

    // Write ports have no handshake: callers hold w0/w1 low while busy; anything
    // presented during reset, the sweep, or the clr request cycle is dropped.
    assign user_we = !sys_rst && !busy && !clr;

    always_ff @(posedge sys_clk) begin
        if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (user_we) begin
            if (w0) regs[addr_w0] <= data_w0;
            // Issued last so it wins an address collision with port 0.
            if (w1) regs[addr_w1] <= data_w1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] q;
        q = regs[addr];
        if (sys_rst || busy)               q = '0;
        else if (w1 && (addr_w1 == addr))  q = data_w1;
        else if (w0 && (addr_w0 == addr))  q = data_w0;
        return q;
    endfunction

    always_comb begin
        qa = read_port(addr_a);
        qb = read_port(addr_b);
    end

endmodule

// File: tb/tb_d8_regfile.sv
// Self-checking bench for d8_regfile: directed steps plus random traffic against
// a behavioural model, then a short run on a 16x32 instance.
module tb_d8_regfile;
    import d8_regfile_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int DW_L = 16;
    localparam int AW_L = 5;
    localparam int DEPTH_L = 32;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic          sys_rst = 1'b1;
    logic          clr = 1'b0;
    logic          busy;
    logic [AW-1:0] addr_a = '0, addr_b = '0, addr_w0 = '0, addr_w1 = '0;
    logic [DW-1:0] qa, qb, data_w0 = '0, data_w1 = '0;
    logic          w0 = 1'b0, w1 = 1'b0;
    rf_state_e     dbg_state;

    logic            sys_rst_l = 1'b1;
    logic            clr_l = 1'b0;
    logic            busy_l;
    logic [AW_L-1:0] addr_a_l = '0, addr_b_l = '0, addr_w0_l = '0, addr_w1_l = '0;
    logic [DW_L-1:0] qa_l, qb_l, data_w0_l = '0, data_w1_l = '0;
    logic            w0_l = 1'b0, w1_l = 1'b0;
    rf_state_e       dbg_state_l;

    d8_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .busy(busy),
        .addr_a(addr_a), .addr_b(addr_b), .qa(qa), .qb(qb),
        .w0(w0), .addr_w0(addr_w0), .data_w0(data_w0),
        .w1(w1), .addr_w1(addr_w1), .data_w1(data_w1),
        .dbg_state(dbg_state)
    );

    d8_regfile #(.DATA_W(DW_L), .ADDR_W(AW_L)) dut_l (
        .sys_clk(sys_clk), .sys_rst(sys_rst_l), .clr(clr_l), .busy(busy_l),
        .addr_a(addr_a_l), .addr_b(addr_b_l), .qa(qa_l), .qb(qb_l),
        .w0(w0_l), .addr_w0(addr_w0_l), .data_w0(data_w0_l),
        .w1(w1_l), .addr_w1(addr_w1_l), .data_w1(data_w1_l),
        .dbg_state(dbg_state_l)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model_mem [DEPTH];
    int            sweep_left = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reads see zero while reset or a sweep is pending; otherwise the newest
    // write wins (w1 over w0 over stored contents).
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (sys_rst || sweep_left > 0) return '0;
        if (w1 && addr_w1 == a)        return data_w1;
        if (w0 && addr_w0 == a)        return data_w0;
        return model_mem[a];
    endfunction

    // A sweep always completes before any write lands, so starting one is
    // equivalent to zeroing the whole model and blocking it for DEPTH edges.
    task automatic model_edge();
        if (sys_rst || clr) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            if (w0) model_mem[addr_w0] = data_w0;
            if (w1) model_mem[addr_w1] = data_w1;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Caller sets inputs just after a falling edge; outputs are checked 1 ns later.
    task automatic cycle();
        #1;
        check("qa", qa, model_read(addr_a));
        check("qb", qb, model_read(addr_b));
        check("busy", busy, (sweep_left > 0) ? 1 : 0);
        check("state", dbg_state, (sweep_left > 0) ? 1 : 0);
        model_edge();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic idle();
        w0 = 1'b0; w1 = 1'b0; clr = 1'b0; sys_rst = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            cycle();
            n++;
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_mem[i]);
        for (int i = 0; i < DEPTH; i++) begin
            addr_a = AW'(i);
            addr_b = AW'(DEPTH - 1 - i);
            #1;
            check(tag, qa, exp_q.pop_front());
            cycle();
        end
    endtask

    task automatic tick_l();
        @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int n2;

        // Reset release: two cycles high, then low.
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        sweep_left = DEPTH;
        cycle();
        idle();
        count_busy(n);
        check("busy_len_reset", n, DEPTH);
        read_all("zero_after_reset");

        // Basic write/read with forwarding then storage.
        w0 = 1'b1; addr_w0 = 4'd3; data_w0 = 8'h5A; addr_a = 4'd3;
        #1 check("fwd_r3", qa, 8'h5A);
        cycle();
        w0 = 1'b0;
        #1 check("stored_r3", qa, 8'h5A);
        cycle();

        // Port collision: w1 wins.
        w0 = 1'b1; addr_w0 = 4'd7; data_w0 = 8'h11;
        w1 = 1'b1; addr_w1 = 4'd7; data_w1 = 8'h22; addr_b = 4'd7;
        #1 check("fwd_collide_r7", qb, 8'h22);
        cycle();
        idle();
        #1 check("stored_collide_r7", qb, 8'h22);
        cycle();
        w0 = 1'b1; addr_w0 = 4'd2; data_w0 = 8'h33;
        w1 = 1'b1; addr_w1 = 4'd4; data_w1 = 8'h44;
        cycle();
        idle();
        addr_a = 4'd2; addr_b = 4'd4;
        #1;
        check("dual_r2", qa, 8'h33);
        check("dual_r4", qb, 8'h44);
        cycle();

        // clr sweep over a full file, with a write attempted while busy.
        for (int i = 0; i < DEPTH; i++) begin
            w0 = 1'b1; addr_w0 = AW'(i); data_w0 = 8'hFF;
            cycle();
        end
        idle();
        addr_a = 4'd9;
        #1 check("filled_r9", qa, 8'hFF);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            w0 = (n == 3); addr_w0 = 4'd1; data_w0 = 8'hAB;
            cycle();
            n++;
        end
        idle();
        check("busy_len_clr", n, DEPTH);
        addr_a = 4'd1;
        #1 check("dropped_r1", qa, 8'h00);
        read_all("zero_after_clr");

        // clr restart five busy cycles in.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        count_busy(n);
        check("busy_len_restart", n + 5, 5 + DEPTH);
        read_all("zero_after_restart");

        // Reset at sweep cycle 9.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        sys_rst = 1'b1;
        cycle();
        sys_rst = 1'b0;
        count_busy(n);
        check("busy_len_rst_mid", n, DEPTH);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            w0 = ($urandom_range(0, 1) == 1);
            w1 = ($urandom_range(0, 2) == 0);
            addr_w0 = AW'($urandom_range(0, DEPTH - 1));
            addr_w1 = AW'($urandom_range(0, DEPTH - 1));
            data_w0 = DW'($urandom);
            data_w1 = DW'($urandom);
            addr_a = ($urandom_range(0, 3) == 0) ? addr_w0 : AW'($urandom_range(0, DEPTH - 1));
            addr_b = ($urandom_range(0, 3) == 0) ? addr_w1 : AW'($urandom_range(0, DEPTH - 1));
            clr = ($urandom_range(0, 59) == 0);
            sys_rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        idle();
        count_busy(n);
        read_all("final_random");

        // 16-bit x 32-entry instance.
        sys_rst_l = 1'b1;
        tick_l();
        tick_l();
        sys_rst_l = 1'b0;
        n2 = 0;
        while (busy_l && n2 < 100) begin
            check("l_q_zero_busy", qa_l, 16'h0000);
            tick_l();
            n2++;
        end
        check("l_busy_len", n2, DEPTH_L);
        w1_l = 1'b1; addr_w1_l = 5'd31; data_w1_l = 16'hBEEF; addr_a_l = 5'd31;
        w0_l = 1'b1; addr_w0_l = 5'd31; data_w0_l = 16'h1234;
        #0 check("l_fwd_beef", qa_l, 16'hBEEF);
        tick_l();
        w0_l = 1'b0; w1_l = 1'b0; addr_b_l = 5'd16;
        #0;
        check("l_stored_beef", qa_l, 16'hBEEF);
        check("l_r16_zero", qb_l, 16'h0000);
        w0_l = 1'b1; addr_w0_l = 5'd16; data_w0_l = 16'hC0DE;
        tick_l();
        w0_l = 1'b0;
        #0 check("l_stored_r16", qb_l, 16'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
